// File: rtl/fpu_pkg.sv
// Shared FPU op-code map, EX sequencer state type and op-decode helpers.
package fpu_pkg;

  localparam logic [4:0] OP_FADD     = 5'b01010;
  localparam logic [4:0] OP_FSUB     = 5'b01011;
  localparam logic [4:0] OP_FMUL     = 5'b01100;
  localparam logic [4:0] OP_FDIV     = 5'b01101;
  localparam logic [4:0] OP_FMIN     = 5'b10001;
  localparam logic [4:0] OP_FMAX     = 5'b10010;
  localparam logic [4:0] OP_FSGNJ    = 5'b10011;
  localparam logic [4:0] OP_FSGNJN   = 5'b10100;
  localparam logic [4:0] OP_FSGNJX   = 5'b10101;
  localparam logic [4:0] OP_FCVT_WS  = 5'b10110;
  localparam logic [4:0] OP_FCVT_WUS = 5'b10111;
  localparam logic [4:0] OP_FMV_XW   = 5'b11000;
  localparam logic [4:0] OP_FCVT_SW  = 5'b11001;
  localparam logic [4:0] OP_FCVT_SWU = 5'b11010;
  localparam logic [4:0] OP_FLE      = 5'b11011;
  localparam logic [4:0] OP_FLT      = 5'b11100;
  localparam logic [4:0] OP_FEQ      = 5'b11101;
  localparam logic [4:0] OP_FMV_WX   = 5'b11110;
  localparam logic [4:0] OP_FSQRT    = 5'b11111;

  localparam logic [31:0] CANON_NAN = 32'h7FC00000;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    DIV_WAIT = 1'b1
  } state_t;

  // Compares, float->int converts and fmv.x.w write the integer register file.
  function automatic logic is_int_dest(input logic [4:0] op);
    case (op)
      OP_FCVT_WS, OP_FCVT_WUS, OP_FMV_XW, OP_FLE, OP_FLT, OP_FEQ: is_int_dest = 1'b1;
      default: is_int_dest = 1'b0;
    endcase
  endfunction

  // Any op code fpu_top understands, including the multi-cycle fdiv.
  function automatic logic is_fpu_op(input logic [4:0] op);
    case (op)
      OP_FADD, OP_FSUB, OP_FMUL, OP_FDIV,
      OP_FMIN, OP_FMAX, OP_FSGNJ, OP_FSGNJN, OP_FSGNJX,
      OP_FCVT_WS, OP_FCVT_WUS, OP_FMV_XW, OP_FCVT_SW, OP_FCVT_SWU,
      OP_FLE, OP_FLT, OP_FEQ, OP_FMV_WX, OP_FSQRT: is_fpu_op = 1'b1;
      default: is_fpu_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fpu_ex_ctrl.sv
// EX-stage sequencer around fpu_top: registers results into the EX/WB slot,
// stalls the pipeline during fdiv and bounds fdiv with a timeout watchdog.
module fpu_ex_ctrl
  import fpu_pkg::*;
#(
  parameter int DIV_TIMEOUT = 64,
  parameter int XLEN        = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic [4:0]      i_alu_op,
  input  logic [4:0]      i_rd,
  input  logic            i_flush,
  input  logic            i_fpu_done,
  input  logic [XLEN-1:0] i_fpu_data,
  output logic            o_stall,
  output logic            o_busy,
  output logic            o_wb_valid,
  output logic [XLEN-1:0] o_wb_data,
  output logic [4:0]      o_wb_rd,
  output logic            o_wb_to_int,
  output logic            o_div_timeout
);

  localparam int CW = $clog2(DIV_TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              wb_valid_q, wb_valid_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic              wb_int_q, wb_int_d;
  logic [4:0]        div_rd_q, div_rd_d;
  logic              tmo_q, tmo_d;
  logic              stall;
  logic              is_div, is_single, timeout_hit;

  assign is_div      = (i_alu_op == OP_FDIV);
  assign is_single   = is_fpu_op(i_alu_op) && !is_div;
  assign timeout_hit = (cnt_q == CNT_MAX);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wb_valid_d = 1'b0;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    wb_int_d   = wb_int_q;
    div_rd_d   = div_rd_q;
    tmo_d      = tmo_q;
    stall      = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_valid && !i_flush) begin
          if (is_single) begin
            wb_valid_d = 1'b1;
            wb_data_d  = i_fpu_data;
            wb_rd_d    = i_rd;
            wb_int_d   = is_int_dest(i_alu_op);
          end else if (is_div) begin
            stall    = 1'b1;
            state_d  = DIV_WAIT;
            cnt_d    = '0;
            div_rd_d = i_rd;
          end
        end
      end
      DIV_WAIT: begin
        // Stall drops in the completing cycle so the pipeline advances with the capture.
        stall = !i_fpu_done && !i_flush && !timeout_hit;
        if (i_flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (i_fpu_done) begin
          state_d    = IDLE;
          cnt_d      = '0;
          wb_valid_d = 1'b1;
          wb_data_d  = i_fpu_data;
          wb_rd_d    = div_rd_q;
          wb_int_d   = 1'b0;
        end else if (timeout_hit) begin
          state_d    = IDLE;
          cnt_d      = '0;
          wb_valid_d = 1'b1;
          wb_data_d  = XLEN'(CANON_NAN);
          wb_rd_d    = div_rd_q;
          wb_int_d   = 1'b0;
          tmo_d      = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      wb_int_q   <= 1'b0;
      div_rd_q   <= '0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
      wb_int_q   <= wb_int_d;
      div_rd_q   <= div_rd_d;
      tmo_q      <= tmo_d;
    end
  end

  // Reset forces stall low even if a held fdiv is still presented upstream.
  assign o_stall       = stall && !i_rst;
  assign o_busy        = (state_q == DIV_WAIT);
  assign o_wb_valid    = wb_valid_q;
  assign o_wb_data     = wb_data_q;
  assign o_wb_rd       = wb_rd_q;
  assign o_wb_to_int   = wb_int_q;
  assign o_div_timeout = tmo_q;

endmodule

// File: tb/tb_fpu_ex_ctrl.sv
// Self-checking bench for fpu_ex_ctrl: directed scenarios plus a randomized
// op stream against a transaction-level reference model.
module tb_fpu_ex_ctrl;

  localparam int DIV_TO = 16;
  localparam int NEVER  = 1000;
  localparam logic [4:0]  FDIV = 5'b01101;
  localparam logic [31:0] NAN  = 32'h7FC00000;
  localparam logic [4:0] SINGLE_OPS [18] = '{5'h0A, 5'h0B, 5'h0C, 5'h11, 5'h12, 5'h13,
                                             5'h14, 5'h15, 5'h16, 5'h17, 5'h18, 5'h19,
                                             5'h1A, 5'h1B, 5'h1C, 5'h1D, 5'h1E, 5'h1F};
  localparam logic [4:0] INT_OPS [6] = '{5'h16, 5'h17, 5'h18, 5'h1B, 5'h1C, 5'h1D};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic [4:0]  i_alu_op = '0;
  logic [4:0]  i_rd = '0;
  logic        i_flush = 1'b0;
  logic        i_fpu_done = 1'b0;
  logic [31:0] i_fpu_data = '0;
  logic        o_stall, o_busy, o_wb_valid, o_wb_to_int, o_div_timeout;
  logic [31:0] o_wb_data;
  logic [4:0]  o_wb_rd;

  int checks = 0;
  int errors = 0;

  // Expected writeback for the next cycle, and the values the slot should hold.
  logic        pend_v = 1'b0, pend_int = 1'b0, pend_tmo = 1'b0;
  logic [31:0] pend_d = '0;
  logic [4:0]  pend_rd = '0;
  logic [31:0] held_d = '0;
  logic [4:0]  held_rd = '0;
  logic        held_int = 1'b0;
  logic        exp_tmo = 1'b0;

  fpu_ex_ctrl #(.DIV_TIMEOUT(DIV_TO), .XLEN(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .i_alu_op(i_alu_op), .i_rd(i_rd),
    .i_flush(i_flush), .i_fpu_done(i_fpu_done), .i_fpu_data(i_fpu_data),
    .o_stall(o_stall), .o_busy(o_busy), .o_wb_valid(o_wb_valid), .o_wb_data(o_wb_data),
    .o_wb_rd(o_wb_rd), .o_wb_to_int(o_wb_to_int), .o_div_timeout(o_div_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic model_single(input logic [4:0] op);
    model_single = 1'b0;
    foreach (SINGLE_OPS[i]) if (SINGLE_OPS[i] == op) model_single = 1'b1;
  endfunction

  function automatic logic model_int(input logic [4:0] op);
    model_int = 1'b0;
    foreach (INT_OPS[i]) if (INT_OPS[i] == op) model_int = 1'b1;
  endfunction

  // One clock cycle: drive inputs just after the edge, check on the falling edge.
  task automatic tick(input logic v, input logic [4:0] op, input logic [4:0] rd,
                      input logic fl, input logic dn, input logic [31:0] d,
                      input logic exp_stall, input logic exp_busy, input string nm);
    logic cv;
    @(posedge clk); #1;
    i_valid = v; i_alu_op = op; i_rd = rd; i_flush = fl; i_fpu_done = dn; i_fpu_data = d;
    cv = pend_v;
    if (cv) begin held_d = pend_d; held_rd = pend_rd; held_int = pend_int; end
    if (pend_tmo) exp_tmo = 1'b1;
    pend_v = 1'b0; pend_tmo = 1'b0;
    @(negedge clk);
    checks += 7;
    if (o_stall !== exp_stall) begin errors++;
      $display("FAIL %s stall: got %b expected %b", nm, o_stall, exp_stall); end
    if (o_busy !== exp_busy) begin errors++;
      $display("FAIL %s busy: got %b expected %b", nm, o_busy, exp_busy); end
    if (o_wb_valid !== cv) begin errors++;
      $display("FAIL %s wb_valid: got %b expected %b", nm, o_wb_valid, cv); end
    if (o_wb_data !== held_d) begin errors++;
      $display("FAIL %s wb_data: got %h expected %h", nm, o_wb_data, held_d); end
    if (o_wb_rd !== held_rd) begin errors++;
      $display("FAIL %s wb_rd: got %0d expected %0d", nm, o_wb_rd, held_rd); end
    if (o_wb_to_int !== held_int) begin errors++;
      $display("FAIL %s wb_to_int: got %b expected %b", nm, o_wb_to_int, held_int); end
    if (o_div_timeout !== exp_tmo) begin errors++;
      $display("FAIL %s div_timeout: got %b expected %b", nm, o_div_timeout, exp_tmo); end
  endtask

  task automatic do_single(input logic v, input logic [4:0] op, input logic [4:0] rd,
                           input logic fl, input logic [31:0] d, input string nm);
    tick(v, op, rd, fl, 1'b0, d, 1'b0, 1'b0, nm);
    if (v && !fl && model_single(op)) begin
      pend_v = 1'b1; pend_d = d; pend_rd = rd; pend_int = model_int(op);
    end
  endtask

  task automatic idle(input string nm);
    tick(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, $urandom, 1'b0, 1'b0, nm);
  endtask

  // fdiv issued at cycle 0; done at cycle kd, flush at cycle kf of DIV_WAIT.
  // It ends at the first of done, flush or the DIV_TO-th wait cycle.
  task automatic do_fdiv(input logic [31:0] d, input logic [4:0] rd,
                         input int kd, input int kf, input string nm);
    int e;
    e = DIV_TO;
    if (kd < e) e = kd;
    if (kf < e) e = kf;
    tick(1'b1, FDIV, rd, 1'b0, 1'b0, $urandom, 1'b1, 1'b0, nm);
    for (int k = 1; k <= e; k++)
      tick(1'b1, FDIV, rd, (k == kf), (k == kd), (k == kd) ? d : $urandom,
           (k < e), 1'b1, nm);
    if (kf != e) begin
      pend_v = 1'b1; pend_rd = rd; pend_int = 1'b0;
      if (kd == e) pend_d = d;
      else begin pend_d = NAN; pend_tmo = 1'b1; end
    end
  endtask

  task automatic test_reset();
    #1;
    checks += 5;
    if (o_busy !== 1'b0 || o_stall !== 1'b0 || o_wb_valid !== 1'b0 ||
        o_div_timeout !== 1'b0 || o_wb_data !== 32'h0) begin
      errors += 5;
      $display("FAIL reset_state: got busy=%b stall=%b wbv=%b tmo=%b data=%h expected all 0",
               o_busy, o_stall, o_wb_valid, o_div_timeout, o_wb_data);
    end
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_single(1'b1, 5'b01010, 5'd3, 1'b0, 32'h40400000, "b2b_fadd");
    do_single(1'b1, 5'b11011, 5'd7, 1'b0, 32'h00000001, "b2b_fle");
    idle("b2b_wb2");
    idle("b2b_hold");
  endtask

  task automatic test_fdiv_done();
    do_fdiv(32'h3F000000, 5'd9, 10, NEVER, "div_done");
    idle("div_done_wb");
    idle("div_done_hold");
  endtask

  task automatic test_fdiv_done_at_timeout();
    do_fdiv(32'h40A00000, 5'd12, DIV_TO, NEVER, "div_done_tmo");
    idle("div_done_tmo_wb");
  endtask

  task automatic test_fdiv_flush();
    do_fdiv(32'h12345678, 5'd4, NEVER, 4, "div_flush");
    tick(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, "div_flush_late_done");
    idle("div_flush_after");
  endtask

  task automatic test_flush_unknown();
    do_single(1'b1, 5'b01100, 5'd5, 1'b1, 32'hCAFEF00D, "flush_fmul");
    do_single(1'b1, 5'b00000, 5'd6, 1'b0, 32'hBADC0DE0, "unknown_op");
    do_single(1'b1, FDIV, 5'd8, 1'b1, 32'h11111111, "flush_fdiv");
    idle("flush_unknown_after");
  endtask

  task automatic test_timeout();
    do_fdiv(32'h0, 5'd14, NEVER, NEVER, "div_timeout");
    do_single(1'b1, 5'b01011, 5'd2, 1'b0, 32'h3F800000, "tmo_sticky_fsub");
    do_single(1'b1, 5'b11101, 5'd1, 1'b0, 32'h00000000, "tmo_sticky_feq");
    idle("tmo_sticky_idle");
  endtask

  task automatic test_reset_mid_div();
    tick(1'b1, FDIV, 5'd10, 1'b0, 1'b0, $urandom, 1'b1, 1'b0, "rst_div_issue");
    for (int k = 1; k <= 6; k++)
      tick(1'b1, FDIV, 5'd10, 1'b0, 1'b0, $urandom, 1'b1, 1'b1, "rst_div_wait");
    #1 rst = 1'b1;
    #1;
    checks += 5;
    if (o_busy !== 1'b0) begin errors++;
      $display("FAIL rst_mid busy: got %b expected 0", o_busy); end
    if (o_stall !== 1'b0) begin errors++;
      $display("FAIL rst_mid stall: got %b expected 0", o_stall); end
    if (o_wb_valid !== 1'b0) begin errors++;
      $display("FAIL rst_mid wb_valid: got %b expected 0", o_wb_valid); end
    if (o_div_timeout !== 1'b0) begin errors++;
      $display("FAIL rst_mid div_timeout: got %b expected 0", o_div_timeout); end
    if (o_wb_data !== 32'h0) begin errors++;
      $display("FAIL rst_mid wb_data: got %h expected 0", o_wb_data); end
    i_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    pend_v = 1'b0; pend_tmo = 1'b0; exp_tmo = 1'b0;
    held_d = '0; held_rd = '0; held_int = 1'b0;
    do_single(1'b1, 5'b01010, 5'd11, 1'b0, 32'h41200000, "rst_after_fadd");
    idle("rst_after_wb");
  endtask

  task automatic test_random();
    logic [4:0] op;
    logic fl, v;
    int kd, kf;
    for (int n = 0; n < 80; n++) begin
      op = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) op = FDIV;
      fl = ($urandom_range(0, 7) == 0);
      v  = ($urandom_range(0, 9) != 0);
      if (v && !fl && op == FDIV) begin
        kd = $urandom_range(1, DIV_TO + 3);
        kf = ($urandom_range(0, 3) == 0) ? $urandom_range(1, DIV_TO + 1) : NEVER;
        do_fdiv($urandom, 5'($urandom_range(0, 31)), kd, kf, "rnd_div");
      end else begin
        do_single(v, op, 5'($urandom_range(0, 31)), fl, $urandom, "rnd_single");
      end
    end
    idle("rnd_drain");
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_fdiv_done();
    test_fdiv_done_at_timeout();
    test_fdiv_flush();
    test_flush_unknown();
    test_timeout();
    test_reset_mid_div();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
